generador_sync_vga: RTL and testbench

Parametrised VGA timing generator, successor to the stand-alone vertical-sync decoder. It owns the horizontal and vertical counters, a pixel-clock-enable divider, and registered HSync, VSync, video_on and pixel coordinates. All porch, sync-width and polarity values are parameters. It sits between the system clock and the pixel/RGB generation logic, which consumes pixel_x, pixel_y, video_on and pixel_tick.

---
 rtl/generador_sync_vga.sv | 125 ++++++++++++
 tb/tb_generador_sync_vga.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_sync_vga.sv
// rtl/generador_sync_vga.sv - parametrised VGA timing generator (counters, sync, video_on, coordinates)
//
// Divides the system clock into a pixel rate, walks a horizontal/vertical
// raster and presents registered, mutually aligned timing outputs.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   en           run enable; low freezes divider and counters
//   HSync        horizontal sync, active level HS_POL
//   VSync        vertical sync, active level VS_POL
//   video_on     current pixel lies in the visible area
//   pixel_x      current horizontal count, 0..H_TOTAL-1
//   pixel_y      current vertical count, 0..V_TOTAL-1
//   pixel_tick   one-clock pulse on the first clock of a new pixel
//   frame_start  one-clock pulse when (0,0) of a new frame appears
module generador_sync_vga #(
    parameter int   CLK_DIV   = 4,
    parameter int   CNT_W     = 10,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             HSync,
    output logic             VSync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pixel_tick,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    // tick_q / wrap_q remember that the counters moved on the previous edge,
    // so pixel_tick and frame_start land on the same clock as the new
    // coordinates rather than one clock ahead of them.
    logic tick_q;
    logic wrap_q;

    logic tick;
    logic h_last;
    logic v_last;
    logic hs_act;
    logic vs_act;
    logic visible;

    assign tick    = en && (div == DIV_LAST);
    assign h_last  = (h_cnt == H_LAST);
    assign v_last  = (v_cnt == V_LAST);
    assign hs_act  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_act  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_tick  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // With CLK_DIV=1 DIV_LAST is 0, so div stays 0 and tick follows en.
            if (en) begin
                div <= tick ? '0 : div + 1'b1;
            end

            if (tick) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end

            tick_q <= tick;
            wrap_q <= tick && h_last && v_last;

            // Outputs follow the counters every clock; while en is low the
            // counters hold, so these hold too.
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            video_on    <= visible;
            HSync       <= hs_act ? HS_POL : ~HS_POL;
            VSync       <= vs_act ? VS_POL : ~VS_POL;
            pixel_tick  <= tick_q;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_generador_sync_vga.sv
// tb/tb_generador_sync_vga.sv - self-checking bench for generador_sync_vga
module tb_generador_sync_vga;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic en  [3];

    // instance 0: defaults; 1: tiny, CLK_DIV=1, active-high syncs; 2: CLK_DIV=3
    logic       d_hs, d_vs, d_vid, d_pt, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_vid, s_pt, s_fs;
    logic [3:0] s_x, s_y;
    logic       m_hs, m_vs, m_vid, m_pt, m_fs;
    logic [4:0] m_x, m_y;

    generador_sync_vga dut (
        .clk(clk), .reset(rst[0]), .en(en[0]),
        .HSync(d_hs), .VSync(d_vs), .video_on(d_vid),
        .pixel_x(d_x), .pixel_y(d_y), .pixel_tick(d_pt), .frame_start(d_fs)
    );

    generador_sync_vga #(
        .CLK_DIV(1), .CNT_W(4),
        .H_VISIBLE(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .clk(clk), .reset(rst[1]), .en(en[1]),
        .HSync(s_hs), .VSync(s_vs), .video_on(s_vid),
        .pixel_x(s_x), .pixel_y(s_y), .pixel_tick(s_pt), .frame_start(s_fs)
    );

    generador_sync_vga #(
        .CLK_DIV(3), .CNT_W(5),
        .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_m (
        .clk(clk), .reset(rst[2]), .en(en[2]),
        .HSync(m_hs), .VSync(m_vs), .video_on(m_vid),
        .pixel_x(m_x), .pixel_y(m_y), .pixel_tick(m_pt), .frame_start(m_fs)
    );

    // {HSync, VSync, video_on, pixel_tick, frame_start, x[9:0], y[9:0]}
    logic [24:0] obs [3];
    assign obs[0] = {d_hs, d_vs, d_vid, d_pt, d_fs, d_x, d_y};
    assign obs[1] = {s_hs, s_vs, s_vid, s_pt, s_fs, 6'd0, s_x, 6'd0, s_y};
    assign obs[2] = {m_hs, m_vs, m_vid, m_pt, m_fs, 5'd0, m_x, 5'd0, m_y};

    int cd  [3] = '{4, 1, 3};
    int ht  [3] = '{800, 10, 13};
    int vt  [3] = '{525, 6, 8};
    int hv  [3] = '{640, 4, 6};
    int vv  [3] = '{480, 2, 4};
    int hs0 [3] = '{656, 6, 8};
    int hsw [3] = '{96, 2, 3};
    int vs0 [3] = '{490, 3, 5};
    int vsw [3] = '{2, 1, 2};
    bit hp  [3] = '{1'b0, 1'b1, 1'b0};
    bit vp  [3] = '{1'b0, 1'b1, 1'b0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: the only state is how many enabled edges and pixel
    // ticks have occurred since reset; position follows by division.
    int          ntk    [3];
    int          encnt  [3];
    bit          ticked [3];
    logic [24:0] expv   [3];
    bit          mvalid [3] = '{1'b0, 1'b0, 1'b0};
    bit          rst_s  [3] = '{1'b1, 1'b1, 1'b1};
    bit          en_s   [3] = '{1'b0, 1'b0, 1'b0};
    bit          rst_p  [3] = '{1'b1, 1'b1, 1'b1};
    bit          en_p   [3] = '{1'b0, 1'b0, 1'b0};
    int          mx, my, nn;
    bit          b_hs, b_vs, b_vid, b_fs;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rst_p[i] = rst_s[i];
            en_p[i]  = en_s[i];
            rst_s[i] = rst[i];
            en_s[i]  = en[i];
            if (rst[i]) begin
                expv[i]   = {~hp[i], ~vp[i], 3'b000, 20'd0};
                ntk[i]    = 0;
                encnt[i]  = 0;
                ticked[i] = 1'b0;
            end else begin
                mx    = ntk[i] % ht[i];
                my    = (ntk[i] / ht[i]) % vt[i];
                b_hs  = (mx >= hs0[i] && mx < hs0[i] + hsw[i]) ? hp[i] : ~hp[i];
                b_vs  = (my >= vs0[i] && my < vs0[i] + vsw[i]) ? vp[i] : ~vp[i];
                b_vid = (mx < hv[i]) && (my < vv[i]);
                b_fs  = ticked[i] && (ntk[i] % (ht[i] * vt[i]) == 0);
                expv[i] = {b_hs, b_vs, b_vid, ticked[i], b_fs, 10'(mx), 10'(my)};
                if (en[i]) begin
                    encnt[i]++;
                    nn        = encnt[i] / cd[i];
                    ticked[i] = (nn != ntk[i]);
                    ntk[i]    = nn;
                end else begin
                    ticked[i] = 1'b0;
                end
            end
            mvalid[i] = 1'b1;
        end
    end

    // Per-cycle model comparison plus interval measurements.
    int cyc = 0;
    int line_start, stall_ls, hs_fall, stall_hs, lines_seen = 0;
    bit have_ls = 1'b0, hs_fall_ok = 1'b0, hs_prev = 1'b1;
    int fcnt [3];
    bit fvalid [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (mvalid[i]) check($sformatf("outputs_%0d", i), 32'(obs[i]), 32'(expv[i]));
        end

        if (rst_s[0]) begin
            have_ls    = 1'b0;
            hs_fall_ok = 1'b0;
        end else begin
            if (!en_p[0]) begin
                stall_ls++;
                stall_hs++;
            end
            if (rst_p[0]) begin
                line_start = cyc;
                stall_ls   = 0;
                have_ls    = 1'b1;
            end else if (d_pt && d_x == 10'd0) begin
                if (have_ls) check("line_period", cyc - line_start, 3200 + stall_ls);
                line_start = cyc;
                stall_ls   = 0;
                have_ls    = 1'b1;
                lines_seen++;
            end
            if (hs_prev && !d_hs) begin
                if (have_ls) check("hsync_offset", cyc - line_start, 2624 + stall_ls);
                hs_fall    = cyc;
                stall_hs   = 0;
                hs_fall_ok = 1'b1;
            end else if (!hs_prev && d_hs && hs_fall_ok) begin
                check("hsync_width", cyc - hs_fall, 384 + stall_hs);
                hs_fall_ok = 1'b0;
            end
        end
        hs_prev = d_hs;

        for (int i = 1; i < 3; i++) begin
            if (rst_s[i]) begin
                fvalid[i] = 1'b0;
            end else begin
                if (en_p[i]) fcnt[i]++;
                if (obs[i][20]) begin
                    if (fvalid[i]) check($sformatf("frame_period_%0d", i), fcnt[i], ht[i] * vt[i] * cd[i]);
                    fcnt[i]   = 0;
                    fvalid[i] = 1'b1;
                end
            end
        end
    end

    // Randomized enable and occasional reset on the two small instances.
    initial begin
        for (int i = 1; i < 3; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        rst[1] = 1'b0;
        rst[2] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 1; i < 3; i++) begin
                en[i]  = ($urandom_range(0, 9) != 0);
                rst[i] = ($urandom_range(0, 1999) == 0);
            end
        end
    end

    task automatic wait_x(input int x, input int budget, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(d_pt && d_x == 10'(x)) && k < budget);
        if (!(d_pt && d_x == 10'(x))) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_lines(input int n, input int budget, input string tag);
        int k, base;
        k    = 0;
        base = lines_seen;
        while (lines_seen < base + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (lines_seen < base + n) check(tag, 32'd0, 32'd1);
    endtask

    int stall_ticks;

    initial begin
        rst[0] = 1'b1;
        en[0]  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hsync", d_hs, 1);
        check("reset_vsync", d_vs, 1);
        check("reset_video_on", d_vid, 0);
        check("reset_pixel_x", d_x, 0);
        rst[0] = 1'b0;

        @(negedge clk);
        check("edge1_video_on", d_vid, 1);
        check("edge1_pixel_x", d_x, 0);
        repeat (3) @(negedge clk);
        check("edge4_pixel_x", d_x, 0);
        check("edge4_pixel_tick", d_pt, 0);
        @(negedge clk);
        check("edge5_pixel_x", d_x, 1);
        check("edge5_pixel_tick", d_pt, 1);

        wait_lines(2, 8000, "timeout_lines_a");
        wait_x(300, 3300, "timeout_x300");
        en[0] = 1'b0;
        stall_ticks = 0;
        repeat (50) begin
            @(negedge clk);
            if (d_pt) stall_ticks++;
        end
        check("stall_pixel_x", d_x, 300);
        check("stall_hsync", d_hs, 1);
        check("stall_ticks", stall_ticks, 0);
        en[0] = 1'b1;

        wait_lines(1, 4000, "timeout_lines_b");
        wait_x(700, 3300, "timeout_x700");
        check("x700_hsync_active", d_hs, 0);
        rst[0] = 1'b1;
        @(negedge clk);
        check("midsync_reset_hsync", d_hs, 1);
        check("midsync_reset_pixel_x", d_x, 0);
        check("midsync_reset_tick", d_pt, 0);
        rst[0] = 1'b0;
        @(negedge clk);
        check("restart_video_on", d_vid, 1);
        repeat (4) @(negedge clk);
        check("restart_pixel_x", d_x, 1);
        check("restart_pixel_tick", d_pt, 1);

        wait_lines(2, 8000, "timeout_lines_c");
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
